// File: rtl/dft_frame_scheduler_if.sv
// Bus bundle of the DFT frame scheduler: HPS CSR slave, writer buffer
// handshake, memory reader trigger and the reader source monitor tap.
interface dft_frame_scheduler_if;
    logic [1:0]  csr_address;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic [1:0]  buffer_full;
    logic [1:0]  buffer_release;
    logic        reader_trigger;
    logic        reader_bank;
    logic        mon_valid;
    logic        mon_ready;
    logic        mon_eop;
    logic        irq;

    modport master (
        output csr_address, csr_write, csr_writedata, csr_read,
        output buffer_full, mon_valid, mon_ready, mon_eop,
        input  csr_readdata, buffer_release, reader_trigger, reader_bank, irq
    );

    modport slave (
        input  csr_address, csr_write, csr_writedata, csr_read,
        input  buffer_full, mon_valid, mon_ready, mon_eop,
        output csr_readdata, buffer_release, reader_trigger, reader_bank, irq
    );
endinterface

// File: rtl/dft_frame_scheduler.sv
// Ping-pong bank scheduler for the DFT memory reader: arbitrates full banks,
// triggers one reader frame per bank, checks frame length/timeout, releases banks.
module dft_frame_scheduler #(
    parameter int FRAME_LEN      = 8192,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    dft_frame_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_STREAM  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_CYCLES);

    state_t            state_r;
    logic [1:0]        pending_r;
    logic              ptr_r;
    logic              reader_bank_r;
    logic              trigger_r;
    logic [1:0]        release_r;
    logic              enable_r;
    logic              single_r;
    logic              overrun_r;
    logic              len_err_r;
    logic              timeout_r;
    logic              irq_en_r;
    logic              irq_pend_r;
    logic              irq_r;
    logic              frame_err_r;
    logic [31:0]       frame_count_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic [31:0]       readdata_r;

    logic              beat_s;
    logic              ctrl_wr_s;
    logic              irq_wr_s;
    logic              clr_err_s;
    logic              reading_s;
    logic              sel_bank_s;
    logic              start_s;
    logic [1:0]        drop_s;
    logic [1:0]        arm_mask_s;
    logic [1:0]        pending_nxt_s;
    logic [CNT_W-1:0]  beat_inc_s;
    logic [CNT_W-1:0]  tmo_inc_s;
    logic              eop_s;
    logic              len_bad_s;
    logic              tmo_hit_s;
    logic              overrun_nxt_s;
    logic              len_err_nxt_s;
    logic              timeout_nxt_s;
    logic              irq_en_nxt_s;
    logic              irq_pend_nxt_s;
    logic              enable_nxt_s;
    logic              single_nxt_s;
    logic [31:0]       rd_mux_s;

    // Next-state terms for pending bits, sticky errors, CSR fields and readback
    always_comb begin
        beat_s     = bus.mon_valid & bus.mon_ready;
        ctrl_wr_s  = bus.csr_write && (bus.csr_address == 2'd0);
        irq_wr_s   = bus.csr_write && (bus.csr_address == 2'd3);
        clr_err_s  = ctrl_wr_s && bus.csr_writedata[2];
        reading_s  = (state_r == S_ARM) || (state_r == S_STREAM);
        sel_bank_s = (pending_r == 2'b11) ? ptr_r : pending_r[1];
        start_s    = (state_r == S_IDLE) && enable_r && (pending_r != 2'b00)
                     && !(overrun_r || len_err_r || timeout_r);
        // The bank under release is already free, so a refill pulse is accepted
        drop_s[0]  = bus.buffer_full[0] && (pending_r[0] || (reading_s && (reader_bank_r == 1'b0)));
        drop_s[1]  = bus.buffer_full[1] && (pending_r[1] || (reading_s && (reader_bank_r == 1'b1)));
        arm_mask_s = start_s ? (sel_bank_s ? 2'b10 : 2'b01) : 2'b00;
        pending_nxt_s = (pending_r | (bus.buffer_full & ~drop_s)) & ~arm_mask_s;

        beat_inc_s = beat_cnt_r + CNT_W'(1);
        tmo_inc_s  = tmo_cnt_r + CNT_W'(1);
        eop_s      = (state_r == S_STREAM) && beat_s && bus.mon_eop;
        len_bad_s  = eop_s && (beat_inc_s != FRAME_LEN_C);
        tmo_hit_s  = (state_r == S_STREAM) && !eop_s && (tmo_inc_s >= TIMEOUT_C);

        // A set in the same cycle as CLR_ERR keeps the error
        overrun_nxt_s  = (drop_s != 2'b00) || (overrun_r && !clr_err_s);
        len_err_nxt_s  = len_bad_s || (len_err_r && !clr_err_s);
        timeout_nxt_s  = tmo_hit_s || (timeout_r && !clr_err_s);
        irq_en_nxt_s   = irq_wr_s ? bus.csr_writedata[0] : irq_en_r;
        irq_pend_nxt_s = (state_r == S_RELEASE) || (irq_pend_r && !(irq_wr_s && bus.csr_writedata[1]));
        single_nxt_s   = ctrl_wr_s ? bus.csr_writedata[1] : single_r;
        enable_nxt_s   = (ctrl_wr_s ? bus.csr_writedata[0] : enable_r)
                         && !((state_r == S_RELEASE) && single_r);

        case (bus.csr_address)
            2'd0:    rd_mux_s = {30'd0, single_r, enable_r};
            2'd1:    rd_mux_s = {24'd0, irq_pend_r, timeout_r, len_err_r, overrun_r,
                                 pending_r, reader_bank_r, (state_r != S_IDLE)};
            2'd2:    rd_mux_s = frame_count_r;
            2'd3:    rd_mux_s = {30'd0, irq_pend_r, irq_en_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Frame FSM with all CSR state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            pending_r     <= 2'b00;
            ptr_r         <= 1'b0;
            reader_bank_r <= 1'b0;
            trigger_r     <= 1'b0;
            release_r     <= 2'b00;
            enable_r      <= 1'b0;
            single_r      <= 1'b0;
            overrun_r     <= 1'b0;
            len_err_r     <= 1'b0;
            timeout_r     <= 1'b0;
            irq_en_r      <= 1'b0;
            irq_pend_r    <= 1'b0;
            irq_r         <= 1'b0;
            frame_err_r   <= 1'b0;
            frame_count_r <= 32'd0;
            beat_cnt_r    <= '0;
            tmo_cnt_r     <= '0;
            readdata_r    <= 32'd0;
        end else begin
            trigger_r  <= 1'b0;
            release_r  <= 2'b00;
            pending_r  <= pending_nxt_s;
            overrun_r  <= overrun_nxt_s;
            len_err_r  <= len_err_nxt_s;
            timeout_r  <= timeout_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            irq_pend_r <= irq_pend_nxt_s;
            irq_r      <= irq_en_nxt_s & irq_pend_nxt_s;
            enable_r   <= enable_nxt_s;
            single_r   <= single_nxt_s;
            if (bus.csr_read) begin
                readdata_r <= rd_mux_s;
            end

            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        state_r       <= S_ARM;
                        reader_bank_r <= sel_bank_s;
                        trigger_r     <= 1'b1;
                        beat_cnt_r    <= '0;
                        tmo_cnt_r     <= '0;
                        frame_err_r   <= 1'b0;
                    end
                end
                S_ARM: begin
                    // The trigger cycle already counts toward the timeout
                    state_r   <= S_STREAM;
                    tmo_cnt_r <= tmo_inc_s;
                end
                S_STREAM: begin
                    tmo_cnt_r <= tmo_inc_s;
                    if (beat_s) begin
                        beat_cnt_r <= beat_inc_s;
                    end
                    if (eop_s || tmo_hit_s) begin
                        state_r     <= S_RELEASE;
                        release_r   <= reader_bank_r ? 2'b10 : 2'b01;
                        frame_err_r <= frame_err_r || len_bad_s || tmo_hit_s;
                    end
                end
                S_RELEASE: begin
                    state_r <= S_IDLE;
                    ptr_r   <= ~reader_bank_r;
                    if (!frame_err_r) begin
                        frame_count_r <= frame_count_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.csr_readdata   = readdata_r;
    assign bus.buffer_release = release_r;
    assign bus.reader_trigger = trigger_r;
    assign bus.reader_bank    = reader_bank_r;
    assign bus.irq            = irq_r;

endmodule
